// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: two-master request/response signals plus the bridge-side bus
interface bus_arbiter_if;
   logic        m0_req, m1_req;
   logic [31:0] m0_addr, m1_addr;
   logic [3:0]  m0_byteen, m1_byteen;
   logic [31:0] m0_wd, m1_wd;
   logic        m0_gnt, m1_gnt;
   logic        m0_rvalid, m1_rvalid;
   logic [31:0] m0_rd, m1_rd;
   logic        m0_err, m1_err;
   logic [31:0] A;
   logic [3:0]  PrByteen;
   logic [31:0] PrWD;
   logic [31:0] PrRD;
   modport slave (
      input  m0_req, m1_req, m0_addr, m1_addr, m0_byteen, m1_byteen, m0_wd, m1_wd, PrRD,
      output m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rd, m1_rd, m0_err, m1_err, A, PrByteen, PrWD
   );
   modport master (
      output m0_req, m1_req, m0_addr, m1_addr, m0_byteen, m1_byteen, m0_wd, m1_wd, PrRD,
      input  m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rd, m1_rd, m0_err, m1_err, A, PrByteen, PrWD
   );
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master arbiter issuing one bridge access per three cycles
module bus_arbiter #(
   parameter bit FIXED_PRIO = 1'b0
) (
   input logic clk,
   input logic reset,
   bus_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t state, nxt;
   logic prio, owner, win, any_req, mapped, err_q, busy, done;
   logic [31:0] addr_q, wd_q, rdata;
   logic [3:0] be_q;
   always_comb begin
      any_req = bus.m0_req | bus.m1_req;
      win = (bus.m0_req & bus.m1_req) ? (FIXED_PRIO ? 1'b0 : prio) : bus.m1_req;
      mapped = (addr_q <= 32'h2FFF) || (addr_q >= 32'h7F00 && addr_q <= 32'h7F0B) ||
               (addr_q >= 32'h7F10 && addr_q <= 32'h7F1B) || (addr_q >= 32'h7F20 && addr_q <= 32'h7F23);
      nxt = state == IDLE ? (any_req ? BUSY : IDLE) : state == BUSY ? DONE : IDLE;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         prio   <= 1'b0;
         owner  <= 1'b0;
         addr_q <= '0;
         be_q   <= '0;
         wd_q   <= '0;
         rdata  <= '0;
         err_q  <= 1'b0;
      end else begin
         state <= nxt;
         if (state == IDLE && any_req) begin
            owner  <= win;
            addr_q <= win ? bus.m1_addr : bus.m0_addr;
            be_q   <= win ? bus.m1_byteen : bus.m0_byteen;
            wd_q   <= win ? bus.m1_wd : bus.m0_wd;
         end
         if (state == BUSY) begin
            rdata <= mapped ? bus.PrRD : '0;
            err_q <= !mapped;
         end
         // round-robin hands priority to the master that just lost out
         if (state == DONE && !FIXED_PRIO) prio <= ~owner;
      end
   end
   always_comb begin
      busy = state == BUSY;
      done = state == DONE;
      bus.A         = busy ? addr_q : '0;
      bus.PrByteen  = (busy && mapped) ? be_q : '0;
      bus.PrWD      = busy ? wd_q : '0;
      bus.m0_gnt    = busy & ~owner;
      bus.m1_gnt    = busy & owner;
      bus.m0_rvalid = done & ~owner;
      bus.m1_rvalid = done & owner;
      bus.m0_rd     = (done && !owner) ? rdata : '0;
      bus.m1_rd     = (done && owner) ? rdata : '0;
      bus.m0_err    = done & ~owner & err_q;
      bus.m1_err    = done & owner & err_q;
   end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: round-robin and fixed-priority arbiters against a transaction-level model
module tb_bus_arbiter;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   bus_arbiter_if bus0 ();
   bus_arbiter_if bus1 ();
   bus_arbiter #(.FIXED_PRIO(1'b0)) dut (.clk(clk), .reset(reset), .bus(bus0.slave));
   bus_arbiter #(.FIXED_PRIO(1'b1)) dut_f (.clk(clk), .reset(reset), .bus(bus1.slave));
   always #5 clk = ~clk;

   function automatic logic [31:0] bridge(input logic [31:0] a);
      return a == 32'h7F04 ? 32'hDEADBEEF : ({a[15:0], a[15:0]} ^ 32'hA5A5_3C3C);
   endfunction
   function automatic bit in_map(input logic [31:0] a);
      return a <= 32'h2FFF || (a >= 32'h7F00 && a <= 32'h7F0B) ||
             (a >= 32'h7F10 && a <= 32'h7F1B) || (a >= 32'h7F20 && a <= 32'h7F23);
   endfunction

   assign bus0.PrRD = bridge(bus0.A);
   assign bus1.PrRD = bridge(bus1.A);
   assign bus1.m0_req = bus0.m0_req;
   assign bus1.m1_req = bus0.m1_req;
   assign bus1.m0_addr = bus0.m0_addr;
   assign bus1.m1_addr = bus0.m1_addr;
   assign bus1.m0_byteen = bus0.m0_byteen;
   assign bus1.m1_byteen = bus0.m1_byteen;
   assign bus1.m0_wd = bus0.m0_wd;
   assign bus1.m1_wd = bus0.m1_wd;

   // one record per arbiter: last accepted transaction, edge it was accepted on, rr pointer
   typedef struct packed {
      bit          ok;
      bit          have;
      logic [31:0] a;
      bit          own;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wd;
      logic [31:0] rd;
      bit          err;
      bit          prio;
   } mdl_t;
   mdl_t m [2] = '{default: '0};

   function automatic mdl_t step(input mdl_t s, input logic [31:0] e, input bit fixed);
      mdl_t r = s;
      if (reset) begin
         r.ok = 1'b1;
         r.have = 1'b0;
         r.prio = 1'b0;
         return r;
      end
      if (s.have && e == s.a + 2 && !fixed) r.prio = !s.own;
      if ((!s.have || e >= s.a + 3) && (bus0.m0_req || bus0.m1_req)) begin
         r.own  = (bus0.m0_req && bus0.m1_req) ? (fixed ? 1'b0 : r.prio) : bus0.m1_req;
         r.have = 1'b1;
         r.a    = e;
         r.addr = r.own ? bus0.m1_addr : bus0.m0_addr;
         r.be   = r.own ? bus0.m1_byteen : bus0.m0_byteen;
         r.wd   = r.own ? bus0.m1_wd : bus0.m0_wd;
         r.err  = !in_map(r.addr);
         r.rd   = r.err ? 32'h0 : bridge(r.addr);
      end
      return r;
   endfunction

   always @(posedge clk) begin
      cyc  <= cyc + 1;
      m[0] <= step(m[0], 32'(cyc + 1), 1'b0);
      m[1] <= step(m[1], 32'(cyc + 1), 1'b1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
      end
   endtask

   task automatic cmp(input int i, input mdl_t s, input logic g0, g1, v0, v1, e0, e1,
                      input logic [31:0] r0, r1, a, wd, input logic [3:0] be);
      bit busy, done, idle, mp;
      busy = s.have && s.a == 32'(cyc);
      done = s.have && s.a + 1 == 32'(cyc);
      idle = !s.have || 32'(cyc) >= s.a + 2;
      mp   = in_map(s.addr);
      chk($sformatf("dut%0d m0_gnt", i), g0, busy && !s.own);
      chk($sformatf("dut%0d m1_gnt", i), g1, busy && s.own);
      chk($sformatf("dut%0d m0_rvalid", i), v0, done && !s.own);
      chk($sformatf("dut%0d m1_rvalid", i), v1, done && s.own);
      chk($sformatf("dut%0d m0_err", i), e0, done && !s.own && s.err);
      chk($sformatf("dut%0d m1_err", i), e1, done && s.own && s.err);
      chk($sformatf("dut%0d m0_rd", i), r0, (done && !s.own) ? s.rd : 32'h0);
      chk($sformatf("dut%0d m1_rd", i), r1, (done && s.own) ? s.rd : 32'h0);
      chk($sformatf("dut%0d PrByteen", i), 32'(be), (busy && mp) ? 32'(s.be) : 32'h0);
      if (busy) chk($sformatf("dut%0d A", i), a, s.addr);
      if (idle) chk($sformatf("dut%0d A idle", i), a, 32'h0);
      if (busy && mp) chk($sformatf("dut%0d PrWD", i), wd, s.wd);
      if (idle) chk($sformatf("dut%0d PrWD idle", i), wd, 32'h0);
   endtask

   always @(negedge clk) begin
      if (m[0].ok)
         cmp(0, m[0], bus0.m0_gnt, bus0.m1_gnt, bus0.m0_rvalid, bus0.m1_rvalid, bus0.m0_err,
             bus0.m1_err, bus0.m0_rd, bus0.m1_rd, bus0.A, bus0.PrWD, bus0.PrByteen);
      if (m[1].ok)
         cmp(1, m[1], bus1.m0_gnt, bus1.m1_gnt, bus1.m0_rvalid, bus1.m1_rvalid, bus1.m0_err,
             bus1.m1_err, bus1.m0_rd, bus1.m1_rd, bus1.A, bus1.PrWD, bus1.PrByteen);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_m(input bit mi, input bit rq, input logic [31:0] ad, input logic [3:0] be,
                        input logic [31:0] wd);
      if (mi) begin
         bus0.m1_req = rq; bus0.m1_addr = ad; bus0.m1_byteen = be; bus0.m1_wd = wd;
      end else begin
         bus0.m0_req = rq; bus0.m0_addr = ad; bus0.m0_byteen = be; bus0.m0_wd = wd;
      end
   endtask

   task automatic xact(input bit mi, input logic [31:0] ad, input logic [3:0] be, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input bit exp_err, input logic [3:0] exp_pbe);
      set_m(mi, 1'b1, ad, be, wd);
      tick;
      chk($sformatf("x%h gnt", ad), mi ? bus0.m1_gnt : bus0.m0_gnt, 32'h1);
      chk($sformatf("x%h A", ad), bus0.A, ad);
      chk($sformatf("x%h PrByteen", ad), 32'(bus0.PrByteen), 32'(exp_pbe));
      if (exp_pbe != 4'h0) chk($sformatf("x%h PrWD", ad), bus0.PrWD, wd);
      tick;
      chk($sformatf("x%h rvalid", ad), mi ? bus0.m1_rvalid : bus0.m0_rvalid, 32'h1);
      chk($sformatf("x%h rd", ad), mi ? bus0.m1_rd : bus0.m0_rd, exp_rd);
      chk($sformatf("x%h err", ad), mi ? bus0.m1_err : bus0.m0_err, 32'(exp_err));
      chk($sformatf("x%h PrByteen done", ad), 32'(bus0.PrByteen), 32'h0);
      set_m(mi, 1'b0, 32'h0, 4'h0, 32'h0);
      tick;
   endtask

   logic [31:0] bnd [6] = '{32'h2FFF, 32'h7F0B, 32'h7F1B, 32'h7F23, 32'h3000, 32'h7F24};
   logic [31:0] pool [14] = '{32'h0, 32'h4, 32'h2FFC, 32'h2FFF, 32'h3000, 32'h7F00, 32'h7F0B,
                              32'h7F0C, 32'h7F10, 32'h7F1B, 32'h7F1C, 32'h7F20, 32'h7F23, 32'h7F24};

   initial begin
      set_m(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      set_m(1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
      tick;
      tick;
      chk("reset A", bus0.A, 32'h0);
      chk("reset gnt", 32'({bus0.m0_gnt, bus0.m1_gnt, bus0.m0_rvalid, bus0.m1_rvalid}), 32'h0);
      reset = 1'b0;
      tick;
      xact(1'b0, 32'h0004, 4'hF, 32'h12345678, bridge(32'h0004), 1'b0, 4'hF);
      xact(1'b1, 32'h7F04, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0, 4'h0);
      xact(1'b0, 32'h7F0C, 4'hF, 32'hCAFEF00D, 32'h0, 1'b1, 4'h0);
      for (int i = 0; i < 6; i++)
         xact(1'b0, bnd[i], 4'h0, 32'h0, i < 4 ? bridge(bnd[i]) : 32'h0, i >= 4, 4'h0);
      // abort an M1 write in BUSY; the pointer was left at M1 but reset returns it to M0
      set_m(1'b1, 1'b1, 32'h0010, 4'hF, 32'h55AA55AA);
      tick;
      chk("abort gnt", bus0.m1_gnt, 32'h1);
      chk("abort PrByteen", 32'(bus0.PrByteen), 32'hF);
      reset = 1'b1;
      tick;
      reset = 1'b0;
      set_m(1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
      chk("abort PrByteen after", 32'(bus0.PrByteen), 32'h0);
      chk("abort rvalid", bus0.m1_rvalid, 32'h0);
      tick;
      chk("abort rvalid late", bus0.m1_rvalid, 32'h0);
      set_m(1'b0, 1'b1, 32'h0100, 4'h0, 32'h0);
      set_m(1'b1, 1'b1, 32'h7F14, 4'h3, 32'h00000077);
      tick;
      chk("post-reset rr m0_gnt", bus0.m0_gnt, 32'h1);
      chk("post-reset rr m1_gnt", bus0.m1_gnt, 32'h0);
      chk("post-reset fixed m0_gnt", bus1.m0_gnt, 32'h1);
      for (int j = 1; j <= 6; j++) begin
         repeat (3) tick;
         chk($sformatf("rr grant %0d m0", j), bus0.m0_gnt, 32'(j % 2 == 0));
         chk($sformatf("rr grant %0d m1", j), bus0.m1_gnt, 32'(j % 2 == 1));
         chk($sformatf("fixed grant %0d m0", j), bus1.m0_gnt, 32'h1);
         chk($sformatf("fixed grant %0d m1", j), bus1.m1_gnt, 32'h0);
      end
      set_m(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      set_m(1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
      repeat (3) tick;
      for (int c = 0; c < 600; c++) begin
         logic [31:0] r;
         r = $urandom;
         reset = r[31:26] == 6'h0;
         set_m(1'b0, r[1:0] != 2'b00, r[4] ? pool[$urandom_range(13)] : {16'h0, r[23:8]},
               r[5] ? 4'h0 : 4'($urandom), $urandom);
         set_m(1'b1, r[3:2] != 2'b00, r[6] ? pool[$urandom_range(13)] : {16'h0, r[29:14]},
               r[7] ? 4'h0 : 4'($urandom), $urandom);
         tick;
      end
      reset = 1'b0;
      repeat (4) tick;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
